// File: rtl/padder.sv
`default_nettype none
// ============================================================================
// Module   : padder
// Purpose  : Packs 64-bit message words into 576-bit (9-word) blocks and
//            applies the pad10*1 rule with byte-level granularity. The last
//            message word keeps its valid bytes, then gets a 0x01 marker byte.
//            Zero words follow until the block is full. Bit 63 of the ninth
//            word of the final block is forced to 1 (pad-end 0x80).
// Revision : 1.0 - initial release
// Option   : PADDER_WORD_CNT_EN - when defined, adds output word_cnt[3:0]
//            that exposes the current word count (0..9).
// Ports    :
//   clk        in   1    rising-edge clock
//   reset      in   1    asynchronous reset, active low
//   in         in   64   message word, byte 0 at [7:0] is first in order
//   in_ready   in   1    in / is_last / byte_num are valid
//   is_last    in   1    current word is the final (possibly partial) word
//   byte_num   in   3    valid bytes in the final word (0..7)
//   ack        out  1    word is consumed at this rising edge (combinational)
//   out        out  576  block; first word at [575:512], last at [63:0]
//   out_ready  out  1    out holds a complete block
//   f_ack      in   1    consumer has taken out
//   word_cnt   out  4    current word count (only with PADDER_WORD_CNT_EN)
// ============================================================================
module padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  in,
  input  logic         in_ready,
  input  logic         is_last,
  input  logic [2:0]   byte_num,
  output logic         ack,
  output logic [575:0] out,
  output logic         out_ready,
  input  logic         f_ack
`ifdef PADDER_WORD_CNT_EN
  ,
  output logic [3:0]   word_cnt
`endif
);

  // Message phase: accepting input words.
  // Pad phase: last word seen, shifting zero words until the block fills.
  // Done phase: final block produced; nothing accepted until reset.
  localparam logic [1:0] c_ST_MSG  = 2'd0;
  localparam logic [1:0] c_ST_PAD  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [3:0] c_BLOCK_WORDS = 4'd9;
  localparam logic [3:0] c_LAST_SLOT   = 4'd8;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [3:0]   r_cnt;
  logic [575:0] r_out;

  logic         w_last_seen;
  logic         w_done;
  logic         w_full;
  logic         w_update;
  logic [63:0]  w_last_word;
  logic [63:0]  w_word;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_MSG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_MSG: begin
        // A last word landing in the ninth slot completes the final block
        // directly; otherwise zero padding is still required.
        if (ack && is_last) begin
          w_state_nxt = (r_cnt == c_LAST_SLOT) ? c_ST_DONE : c_ST_PAD;
        end
      end
      c_ST_PAD: begin
        if (w_update && (r_cnt == c_LAST_SLOT)) begin
          w_state_nxt = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        w_state_nxt = c_ST_DONE;
      end
      default: begin
        w_state_nxt = c_ST_MSG;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / control logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_last_seen = (r_state == c_ST_PAD);
    w_done      = (r_state == c_ST_DONE);
    w_full      = (r_cnt == c_BLOCK_WORDS);
    // reset gates ack so it drops immediately, without waiting for a clock.
    ack         = reset & in_ready & ~w_full & ~w_last_seen & ~w_done;
    w_update    = ack | (w_last_seen & ~w_full);
  end

  // --------------------------------------------------------------------------
  // Word formation
  // --------------------------------------------------------------------------
  always_comb begin
    w_last_word = 64'h0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < {1'b0, byte_num}) begin
        w_last_word[8*k +: 8] = in[8*k +: 8];
      end else if (4'(k) == {1'b0, byte_num}) begin
        w_last_word[8*k +: 8] = 8'h01;
      end else begin
        w_last_word[8*k +: 8] = 8'h00;
      end
    end

    if (w_last_seen) begin
      w_word = 64'h0;
    end else if (is_last) begin
      w_word = w_last_word;
    end else begin
      w_word = in;
    end

    // The ninth word of the final block carries the closing pad bit, whether
    // it is a padding word or the last message word itself.
    if ((r_cnt == c_LAST_SLOT) && (w_last_seen || is_last)) begin
      w_word[63] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Block shift register and word counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= 576'h0;
      r_cnt <= 4'd0;
    end else if (w_full && f_ack) begin
      // Only the count clears; out keeps the block until it is overwritten.
      r_cnt <= 4'd0;
    end else if (w_update) begin
      r_out <= {r_out[511:0], w_word};
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign out       = r_out;
  assign out_ready = w_full;

`ifdef PADDER_WORD_CNT_EN
  assign word_cnt  = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_padder
// Purpose  : Self-checking bench for padder. Expected blocks are queued as
//            stimulus is driven and compared when out_ready rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_padder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  in = 64'h0;
  logic         in_ready = 1'b0;
  logic         is_last = 1'b0;
  logic [2:0]   byte_num = 3'd0;
  logic         ack;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;
`ifdef PADDER_WORD_CNT_EN
  logic [3:0]   word_cnt;
`endif

  padder dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_ready  (in_ready),
    .is_last   (is_last),
    .byte_num  (byte_num),
    .ack       (ack),
    .out       (out),
    .out_ready (out_ready),
    .f_ack     (f_ack)
`ifdef PADDER_WORD_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [63:0] c_W = 64'h1234567890ABCDEF;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [575:0] sb[$];
  logic [575:0] mon_exp;
  logic         prev_or   = 1'b0;
  logic         man_fack  = 1'b0;
  logic         auto_fack = 1'b0;

  // f_ack driver: changes only on the falling edge so it is stable at posedge.
  initial begin
    f_ack = 1'b0;
    forever begin
      @(negedge clk);
      f_ack = man_fack | (auto_fack & out_ready);
    end
  end

  // Scoreboard monitor: every new full block must match the queue head.
  always @(negedge clk) begin
    if (out_ready && !prev_or) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL block_unexpected: got %h, required no block", out);
      end else begin
        mon_exp = sb.pop_front();
        if (out !== mon_exp) begin
          $display("FAIL block_data: got %h required %h", out, mon_exp);
        end else begin
          n_pass++;
        end
      end
    end
    prev_or = out_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_ready = 1'b0;
    man_fack = 1'b0;
    reset    = 1'b0;
    tick();
    tick();
    reset    = 1'b1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic l,
                           input logic [2:0] b);
    bit got = 1'b0;
    in       = d;
    is_last  = l;
    byte_num = b;
    in_ready = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (ack === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL send_timeout: ack=%b, required 1 within 60 cycles", ack);
    end
    tick();
  endtask

  task automatic test_reset();
    in_ready = 1'b1;
    in       = c_W;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (out !== 576'h0) $display("FAIL reset_out: got %h required 0", out);
    else n_pass++;
    n_checks++;
    if (out_ready !== 1'b0) $display("FAIL reset_out_ready: got %b required 0", out_ready);
    else n_pass++;
    n_checks++;
    if (ack !== 1'b0) $display("FAIL reset_ack: got %b required 0", ack);
    else n_pass++;
`ifdef PADDER_WORD_CNT_EN
    n_checks++;
    if (word_cnt !== 4'd0) $display("FAIL reset_word_cnt: got %0d required 0", word_cnt);
    else n_pass++;
`endif
    in_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_empty_msg();
    logic [575:0] exp_blk;
    bit seen = 1'b0;
    exp_blk = {64'h1, 448'h0, 64'h8000000000000000};
    sb.push_back(exp_blk);
    in       = 64'hFFFF_FFFF_FFFF_FFFF;
    is_last  = 1'b1;
    byte_num = 3'd0;
    in_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b1) $display("FAIL empty_ack_first: got %b required 1", ack);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0) $display("FAIL empty_ack_padding: got %b required 0", ack);
    else n_pass++;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_ready === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen) $display("FAIL empty_out_ready: got %b required 1 within 20 cycles", out_ready);
    else n_pass++;
    n_checks++;
    if (ack !== 1'b0) $display("FAIL empty_ack_full: got %b required 0", ack);
    else n_pass++;
    tick();
    man_fack = 1'b1;
    tick();
    man_fack = 1'b0;
    n_checks++;
    if (out_ready !== 1'b0) $display("FAIL empty_after_fack: out_ready=%b required 0", out_ready);
    else n_pass++;
    n_checks++;
    if (out !== exp_blk) $display("FAIL empty_out_held: got %h required %h", out, exp_blk);
    else n_pass++;
    repeat (10) tick();
    n_checks++;
    if (out_ready !== 1'b0 || ack !== 1'b0)
      $display("FAIL empty_done_idle: out_ready=%b ack=%b required 0 0", out_ready, ack);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [575:0] exp_blk;
    exp_blk = {9{c_W}};
    sb.push_back(exp_blk);
    in       = c_W;
    is_last  = 1'b0;
    byte_num = 3'd0;
    in_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b1) $display("FAIL b2b_ack word %0d: got %b required 1", i, ack);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (out_ready !== 1'b1) $display("FAIL b2b_out_ready: got %b required 1", out_ready);
    else n_pass++;
`ifdef PADDER_WORD_CNT_EN
    n_checks++;
    if (word_cnt !== 4'd9) $display("FAIL b2b_word_cnt: got %0d required 9", word_cnt);
    else n_pass++;
`endif
    tick();
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0) $display("FAIL b2b_stall_ack: got %b required 0", ack);
    else n_pass++;
    tick();
    man_fack = 1'b1;
    tick();
    man_fack = 1'b0;
    n_checks++;
    if (out_ready !== 1'b0) $display("FAIL b2b_after_fack: out_ready=%b required 0", out_ready);
    else n_pass++;
    n_checks++;
    if (out !== exp_blk) $display("FAIL b2b_out_held: got %h required %h", out, exp_blk);
    else n_pass++;
    n_checks++;
    if (ack !== 1'b1) $display("FAIL b2b_resume_ack: got %b required 1", ack);
    else n_pass++;
    in_ready = 1'b0;
  endtask

  task automatic test_partial_last();
    sb.push_back({{8{c_W}}, 64'h8001567890ABCDEF});
    for (int i = 0; i < 8; i++) send_word(c_W, 1'b0, 3'd0);
    in       = c_W;
    is_last  = 1'b1;
    byte_num = 3'd6;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b1) $display("FAIL partial_no_bubble: ack=%b required 1", ack);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (out_ready !== 1'b1) $display("FAIL partial_out_ready: got %b required 1", out_ready);
    else n_pass++;
    tick();
    man_fack = 1'b1;
    tick();
    man_fack = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (out_ready !== 1'b0 || ack !== 1'b0)
      $display("FAIL partial_done_idle: out_ready=%b ack=%b required 0 0", out_ready, ack);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    send_word(64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 3'd0);
    send_word(64'h1111_2222_3333_4444, 1'b0, 3'd0);
    in = 64'h5555_6666_7777_8888;
    // reset drops between clock edges; outputs must clear without an edge
    reset = 1'b0;
    #1;
    n_checks++;
    if (out !== 576'h0 || out_ready !== 1'b0 || ack !== 1'b0)
      $display("FAIL reset_mid: out=%h out_ready=%b ack=%b required all 0", out, out_ready, ack);
    else n_pass++;
    in_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_last_full(input logic [2:0] b, input logic [63:0] exp_last);
    sb.push_back({{8{c_W}}, exp_last});
    for (int i = 0; i < 8; i++) send_word(c_W, 1'b0, 3'd0);
    send_word(c_W, 1'b1, b);
    in_ready = 1'b0;
    tick();
    tick();
    man_fack = 1'b1;
    tick();
    man_fack = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [63:0]  words[$];
      logic [63:0]  data_q[$];
      logic [63:0]  ld, mask, pw, tmp;
      logic [575:0] blk;
      int           n, lbi;
      n   = $urandom_range(0, 15);
      lbi = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        tmp = {$urandom, $urandom};
        data_q.push_back(tmp);
        words.push_back(tmp);
      end
      ld   = {$urandom, $urandom};
      mask = (64'h1 << (8 * lbi)) - 64'h1;
      pw   = (ld & mask) | (64'h1 << (8 * lbi));
      words.push_back(pw);
      while (words.size() % 9 != 0) words.push_back(64'h0);
      tmp = words[words.size() - 1];
      tmp[63] = 1'b1;
      words[words.size() - 1] = tmp;
      for (int b = 0; b < words.size() / 9; b++) begin
        blk = 576'h0;
        for (int j = 0; j < 9; j++) blk = {blk[511:0], words[9 * b + j]};
        sb.push_back(blk);
      end
      auto_fack = 1'b1;
      foreach (data_q[i]) send_word(data_q[i], 1'b0, 3'd0);
      send_word(ld, 1'b1, 3'(lbi));
      in_ready = 1'b0;
      for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
      n_checks++;
      if (sb.size() != 0)
        $display("FAIL random_drain iter %0d: pending=%0d required 0", it, sb.size());
      else n_pass++;
      tick();
      tick();
      tick();
      auto_fack = 1'b0;
      do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_empty_msg();
    test_back_to_back();
    test_partial_last();
    test_reset_mid();
    test_last_full(3'd7, 64'h8134567890ABCDEF);
    test_last_full(3'd0, 64'h8000000000000001);
    test_random();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_empty: pending=%0d required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
